branch_pc_unit: RTL

Sequencer that consumes the CON flip-flop result and owns the program counter for the mini-SRC datapath. The control unit pulses `start` once per branch/jump instruction after CON has been loaded. The block then decodes the instruction, applies the branch condition, and commits the next PC. It also performs ordinary PC increments during fetch and, optionally, produces the link write for `jal`.

---
 rtl/src_isa_pkg.sv | 33 +++
 rtl/branch_pc_unit_if.sv | 28 ++
 rtl/branch_target_calc.sv | 35 +++
 rtl/branch_pc_unit.sv | 116 +++++++++++
 4 files changed

// File: rtl/src_isa_pkg.sv
// Purpose: shared mini-SRC ISA constants, field positions and branch/PC FSM types.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package src_isa_pkg;

    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 27;
    localparam int C2_MSB  = 22;
    localparam int C2_LSB  = 19;
    localparam int C_MSB   = 18;
    localparam int C_LSB   = 0;

    localparam logic [4:0] OP_BR  = 5'b10010;
    localparam logic [4:0] OP_JR  = 5'b10011;
    localparam logic [4:0] OP_JAL = 5'b10100;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EVAL   = 2'd1,
        ST_UPDATE = 2'd2,
        ST_DONE   = 2'd3
    } bpc_state_t;

    typedef struct packed {
        logic        taken;
        logic [31:0] target;
    } bpc_res_t;

    function automatic logic [31:0] sext_c(input logic [18:0] c);
        return {{13{c[18]}}, c};
    endfunction

endpackage

// File: rtl/branch_pc_unit_if.sv
// Purpose: control-unit <-> branch/PC unit signal bundle.
// Latency: n/a (wiring only).
// Backpressure: none; busy tells the master that start/pc_inc are being ignored.
interface branch_pc_unit_if;

    logic        start;
    logic        pc_inc;
    logic [31:0] instruction;
    logic        con;
    logic [31:0] rs_value;
    logic [31:0] pc;
    logic        busy;
    logic        done;
    logic        taken;
    logic        link_we;
    logic [31:0] link_data;

    modport master (
        output start, pc_inc, instruction, con, rs_value,
        input  pc, busy, done, taken, link_we, link_data
    );

    modport slave (
        input  start, pc_inc, instruction, con, rs_value,
        output pc, busy, done, taken, link_we, link_data
    );

endinterface

// File: rtl/branch_target_calc.sv
// Purpose: decide taken/target for br, jr and (with BRANCH_PC_JAL_EN) jal.
// Latency: combinational.
// Backpressure: none.
module branch_target_calc
    import src_isa_pkg::*;
(
    input  logic [4:0]  opcode,
    input  logic        con,
    input  logic [31:0] pc,
    input  logic [18:0] c,
    input  logic [31:0] rs_value,
    output bpc_res_t    res
);

    always_comb begin
        res.taken  = 1'b0;
        res.target = pc;
        if (opcode == OP_BR) begin
            if (con) begin
                res.taken  = 1'b1;
                res.target = pc + sext_c(c);
            end
        end else if (opcode == OP_JR) begin
            res.taken  = 1'b1;
            res.target = rs_value;
        end
`ifdef BRANCH_PC_JAL_EN
        else if (opcode == OP_JAL) begin
            res.taken  = 1'b1;
            res.target = rs_value;
        end
`endif
    end

endmodule

// File: rtl/branch_pc_unit.sv
// Purpose: owns the PC; resolves br/jr/jal after CON is loaded, link write when BRANCH_PC_JAL_EN is defined.
// Latency: start at edge N -> pc updated at N+2, done high in the cycle after N+2; pc_inc takes effect at its own edge.
// Backpressure: start/pc_inc are dropped (not queued) while busy; start beats pc_inc in IDLE.
module branch_pc_unit
    import src_isa_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             clr,
    branch_pc_unit_if.slave  bus
);

    bpc_state_t  state;
    logic [31:0] pc_q;
    logic        busy_q;
    logic        done_q;
    logic        taken_q;
    logic [31:0] target_q;
    logic [4:0]  op_q;
    logic [18:0] c_q;
    logic        con_q;
    logic [31:0] rs_q;
    bpc_res_t    res;

    // ra and C2 are decoded by the control unit, not here.
    logic unused_fields;
    assign unused_fields = ^bus.instruction[OPC_LSB-1:C_MSB+1];

    branch_target_calc u_calc (
        .opcode   (op_q),
        .con      (con_q),
        .pc       (pc_q),
        .c        (c_q),
        .rs_value (rs_q),
        .res      (res)
    );

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state    <= ST_IDLE;
            pc_q     <= RESET_PC;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            taken_q  <= 1'b0;
            target_q <= '0;
            op_q     <= '0;
            c_q      <= '0;
            con_q    <= 1'b0;
            rs_q     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        op_q   <= bus.instruction[OPC_MSB:OPC_LSB];
                        c_q    <= bus.instruction[C_MSB:C_LSB];
                        con_q  <= bus.con;
                        rs_q   <= bus.rs_value;
                        busy_q <= 1'b1;
                        state  <= ST_EVAL;
                    end else if (bus.pc_inc) begin
                        pc_q <= pc_q + 32'd1;
                    end
                end
                ST_EVAL: begin
                    taken_q  <= res.taken;
                    target_q <= res.target;
                    state    <= ST_UPDATE;
                end
                ST_UPDATE: begin
                    if (taken_q) begin
                        pc_q <= target_q;
                    end
                    done_q <= 1'b1;
                    state  <= ST_DONE;
                end
                ST_DONE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef BRANCH_PC_JAL_EN
    logic        link_we_q;
    logic [31:0] link_data_q;

    // Strobe lands in UPDATE, while pc still holds the pre-jump value.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            link_we_q   <= 1'b0;
            link_data_q <= '0;
        end else begin
            link_we_q <= (state == ST_EVAL) && (op_q == OP_JAL);
            if ((state == ST_EVAL) && (op_q == OP_JAL)) begin
                link_data_q <= pc_q;
            end
        end
    end

    assign bus.link_we   = link_we_q;
    assign bus.link_data = link_data_q;
`else
    assign bus.link_we   = 1'b0;
    assign bus.link_data = '0;
`endif

    assign bus.pc    = pc_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.taken = taken_q;

endmodule
